serial_rbs: RTL and testbench
=============================

Name: serial_rbs

Overview:
Bit-serial ripple-borrow subtractor: the multi-cycle subtract counterpart to the team's combinational ripple-carry adder.
- Computes diff = a - b - bin over N clock cycles, one bit per cycle from LSB up, through a single full-subtractor cell.
- Uses a start/busy/done handshake.
- Sits in datapaths where area matters more than latency, and serves as the checker-friendly inverse of the adder (a + b, then subtract b, returns a).

Parameters:
N, 4, operand and result width in bits (N >= 1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request; sampled only when not busy
a  input  N  minuend, captured on accepted start
b  input  N  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when diff/bout become valid
diff  output  N  result a - b - bin (mod 2^N)
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous) forces state IDLE. It clears busy, done, diff, bout, the bit counter, the borrow register and the operand shift registers to 0. It takes effect immediately, including mid-operation; no partial result is ever presented.
- States:
  - IDLE: busy = 0. On start = 1, latch a, b and bin, clear counter, go to RUN.
  - RUN: busy = 1. Each cycle processes bit i = counter:
    - d = a[i] ^ b[i] ^ br
    - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
    - d shifts into the result register from the MSB end; operand registers shift right; counter increments.
    - On the edge that processes bit N-1: load diff from the completed shift register, load bout = br_next, set done = 1, go to DONE.
  - DONE: busy = 0, done = 1 for exactly this one cycle, then go to IDLE. If start = 1 in DONE, accept it exactly as IDLE would and go straight to RUN, which gives back-to-back operation.
- Latency: start accepted on edge k gives done = 1 in the cycle following edge k + N. Throughput is one result per N + 1 cycles.
- diff and bout hold their last value until the next completion. They do not change during RUN; the working result lives in an internal shift register.
- start while busy = 1 is ignored. Operand inputs are don't-care except in the accepting cycle.
- The counter is ceil(log2(N+1)) bits wide and must not wrap before N. For N = 1, RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^N. bout = 1 when borrow propagates out of bit N-1. diff equals (a - b - bin) & (2^N - 1) for all inputs.

Decomposition:
- Shared include file holds:
  - state encoding localparams: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - the counter-width function.
- Sub-module fs1 is the combinational 1-bit full subtractor (inputs x, y, bi; outputs d, bo). It is also reusable by a future ripple-borrow combinational block.
- serial_rbs instantiates one fs1 and holds the FSM, counter and shift registers.

Test Plan:
- N=4, a=0011, b=0001, bin=0, start pulse -> after 4 RUN cycles, done pulse; diff=0010, bout=0; busy high for exactly 4 cycles.
- a=0001, b=0010, bin=0 -> diff=1111, bout=1. Then a=1010, b=0101, bin=0 -> diff=0101, bout=0.
- Boundaries:
  - a=0000, b=0000, bin=1 -> diff=1111, bout=1
  - a=1111, b=1111, bin=1 -> diff=1111, bout=1
  - a=0000, b=0000, bin=0 -> diff=0000, bout=0
- Handshake:
  - start held high with new operands during RUN -> ignored; result matches the first operands.
  - start asserted in the DONE cycle -> accepted; second done exactly 5 cycles after the first.
- Reset mid-operation: rst_n low 2 cycles into RUN -> busy, done, diff and bout go to 0 immediately, without a clock edge. After release, a fresh start with a=1000, b=0001 -> diff=0111, bout=0.
- Randomized self-check: 500 random (a, b, bin) for N=4 and N=1 -> diff and bout match the reference a - b - bin. Also check adder round-trip: RCA(a, b) result minus b equals a.

Source files
------------

// File: rtl/serial_rbs_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor:
// FSM state encoding and the bit-counter width helper.
package serial_rbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Wide enough to count 0..n without wrapping
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_rbs_fs1.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module serial_rbs_fs1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_rbs.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per cycle
// from the LSB through a single full-subtractor cell, with start/busy/done.
module serial_rbs
  import serial_rbs_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   res_q, res_d, diff_q, diff_d;
  logic           br_q, br_d, bout_q, bout_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bit_d, bit_bo;
  logic [N:0]     res_shift;

  serial_rbs_fs1 u_fs1 (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place after N shifts
  assign res_shift = {bit_d, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bit_bo;
        res_d = res_shift[N:1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_shift[N:1];
          bout_d  = bit_bo;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_rbs.sv
// Directed, table-driven and random checks of serial_rbs at N=4 and N=1.
module tb_serial_rbs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_rbs #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  serial_rbs #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one N=4 operation; start stays high for 'hold' extra cycles with scrambled operands
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin, input int hold,
                     output logic [3:0] d, output logic bo, output int busy_cyc, output int lat,
                     output logic stable);
    logic [3:0] d_before;
    @(negedge clk);
    d_before = diff4;
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    lat = 0; busy_cyc = 0; stable = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat > hold) start4 = 1'b0;
      else begin a4 = ~a; b4 = ~b; bin4 = ~bin; end
      if (busy4) begin
        busy_cyc++;
        if (diff4 !== d_before || bout4 === 1'bx) stable = 1'b0;
      end
      if (done4) break;
    end
    start4 = 1'b0;
    if (!done4) check("op4_timeout", 32'(lat), 32'd5);
    d = diff4; bo = bout4;
  endtask

  task automatic op1(input logic a, input logic b, input logic bin,
                     output logic d, output logic bo, output int lat);
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      start1 = 1'b0;
      if (done1) break;
    end
    if (!done1) check("op1_timeout", 32'(lat), 32'd2);
    d = diff1[0]; bo = bout1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d, ea, eb, s;
    logic       bo, ebin, stable, d1, bo1;
    logic [4:0] ref5;
    logic [1:0] ref2;
    int         busy_cyc, lat;

    vecs[0] = '{"basic_3m1",   4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0};
    vecs[1] = '{"under_1m2",   4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1};
    vecs[2] = '{"alt_10m5",    4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0};
    vecs[3] = '{"zero_bin1",   4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vecs[4] = '{"ones_bin1",   4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vecs[5] = '{"zero_bin0",   4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[6] = '{"msb_8m1",     4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0};
    vecs[7] = '{"neg_7m9m1",   4'b0111, 4'b1001, 1'b1, 4'b1101, 1'b1};

    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy4), 32'd0);
    check("reset_done", 32'(done4), 32'd0);
    check("reset_diff", 32'(diff4), 32'd0);
    check("reset_bout", 32'(bout4), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].bin, 0, d, bo, busy_cyc, lat, stable);
      check({vecs[i].name, "_diff"}, 32'(d), 32'(vecs[i].diff));
      check({vecs[i].name, "_bout"}, 32'(bo), 32'(vecs[i].bout));
      check({vecs[i].name, "_busy_cycles"}, 32'(busy_cyc), 32'd4);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd5);
      check({vecs[i].name, "_diff_stable"}, 32'(stable), 32'd1);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, 32'(done4), 32'd0);
    end

    // start held high with other operands while busy must be ignored
    op4(4'b1100, 4'b0011, 1'b0, 2, d, bo, busy_cyc, lat, stable);
    check("hold_start_diff", 32'(d), 32'h9);
    check("hold_start_bout", 32'(bo), 32'd0);
    check("hold_start_latency", 32'(lat), 32'd5);

    // start in the DONE cycle: accepted, next done 5 cycles later
    op4(4'b0101, 4'b0011, 1'b0, 0, d, bo, busy_cyc, lat, stable);
    check("b2b_first_diff", 32'(d), 32'h2);
    a4 = 4'b0010; b4 = 4'b0100; bin4 = 1'b1; start4 = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      start4 = 1'b0;
      if (done4) break;
    end
    check("b2b_spacing", 32'(lat), 32'd5);
    check("b2b_second_diff", 32'(diff4), 32'hD);
    check("b2b_second_bout", 32'(bout4), 32'd1);

    // asynchronous reset two cycles into RUN
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'b0001; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", 32'(busy4), 32'd1);
    check("pre_reset_diff", 32'(diff4), 32'hD);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy4), 32'd0);
    check("async_reset_done", 32'(done4), 32'd0);
    check("async_reset_diff", 32'(diff4), 32'd0);
    check("async_reset_bout", 32'(bout4), 32'd0);
    repeat (2) @(negedge clk);
    check("reset_hold_busy", 32'(busy4), 32'd0);
    rst_n = 1'b1;
    op4(4'b1000, 4'b0001, 1'b0, 0, d, bo, busy_cyc, lat, stable);
    check("post_reset_diff", 32'(d), 32'h7);
    check("post_reset_bout", 32'(bo), 32'd0);

    // N=1 corner: RUN lasts exactly one cycle
    op1(1'b0, 1'b1, 1'b0, d1, bo1, lat);
    check("n1_0m1_diff", 32'(d1), 32'd1);
    check("n1_0m1_bout", 32'(bo1), 32'd1);
    check("n1_latency", 32'(lat), 32'd2);

    for (int i = 0; i < 500; i++) begin
      ea = 4'($urandom_range(0, 15));
      eb = 4'($urandom_range(0, 15));
      ebin = 1'($urandom_range(0, 1));
      ref5 = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
      op4(ea, eb, ebin, 0, d, bo, busy_cyc, lat, stable);
      check("rand4_diff", 32'(d), 32'(ref5[3:0]));
      check("rand4_bout", 32'(bo), 32'(ref5[4]));
    end

    for (int i = 0; i < 500; i++) begin
      ea = 4'($urandom_range(0, 1));
      eb = 4'($urandom_range(0, 1));
      ebin = 1'($urandom_range(0, 1));
      ref2 = {1'b0, ea[0]} - {1'b0, eb[0]} - {1'b0, ebin};
      op1(ea[0], eb[0], ebin, d1, bo1, lat);
      check("rand1_diff", 32'(d1), 32'(ref2[0]));
      check("rand1_bout", 32'(bo1), 32'(ref2[1]));
    end

    // adder round trip: (a + b) - b returns a, borrow mirrors the add carry
    for (int i = 0; i < 50; i++) begin
      ea = 4'($urandom_range(0, 15));
      eb = 4'($urandom_range(0, 15));
      ref5 = {1'b0, ea} + {1'b0, eb};
      s = ref5[3:0];
      op4(s, eb, 1'b0, 0, d, bo, busy_cyc, lat, stable);
      check("roundtrip_diff", 32'(d), 32'(ea));
      check("roundtrip_bout", 32'(bo), 32'(ref5[4]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
